// File: rtl/ctrl_pipe.sv
// Pipeline control-bundle registers (ID/EX, EX/MEM, MEM/WB) with load-use stall and branch/jump flush.
// Define CTRL_PIPE_EVENT_CNT_EN to build the saturating stall/flush event counters.
module ctrl_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [8:0]       EX_id,
  input  logic [4:0]       M_id,
  input  logic [3:0]       WB_id,
  input  logic             ID_id,
  input  logic [4:0]       Rs_id,
  input  logic [4:0]       Rt_id,
  input  logic             BranchTaken_mem,
  output logic [8:0]       EX_ex,
  output logic [4:0]       M_ex,
  output logic [3:0]       WB_ex,
  output logic [4:0]       M_mem,
  output logic [3:0]       WB_mem,
  output logic [3:0]       WB_wb,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFFlush,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned EX_W  = 9;
  localparam int unsigned M_W   = 5;
  localparam int unsigned WB_W  = 4;
  localparam int unsigned REG_W = 5;
  localparam int unsigned MEM_READ_BIT = 3;

  logic [EX_W-1:0]  ex_ex_q,  ex_ex_d;
  logic [M_W-1:0]   m_ex_q,   m_ex_d;
  logic [WB_W-1:0]  wb_ex_q,  wb_ex_d;
  logic [REG_W-1:0] rt_ex_q,  rt_ex_d;
  logic [M_W-1:0]   m_mem_q,  m_mem_d;
  logic [WB_W-1:0]  wb_mem_q, wb_mem_d;
  logic [WB_W-1:0]  wb_wb_q,  wb_wb_d;

  logic stall;
  logic stall_eff;
  logic flush;

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    stall = 1'b0;
    if (m_ex_q[MEM_READ_BIT] && (rt_ex_q != REG_W'(0)) &&
        ((rt_ex_q == Rs_id) || (rt_ex_q == Rt_id))) begin
      stall = 1'b1;
    end
  end

  assign flush     = BranchTaken_mem;
  assign stall_eff = stall & ~flush;

  // Fetch-stage controls; a taken branch overrides any stall.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFFlush   = 1'b0;
    if (flush) begin
      IFFlush = 1'b1;
    end else if (stall) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (ID_id) begin
      IFFlush = 1'b1;
    end
  end

  // Next state of the control bundles; MEM/WB always advances so MEM still writes back.
  always_comb begin
    ex_ex_d  = EX_id;
    m_ex_d   = M_id;
    wb_ex_d  = WB_id;
    rt_ex_d  = Rt_id;
    m_mem_d  = m_ex_q;
    wb_mem_d = wb_ex_q;
    wb_wb_d  = wb_mem_q;
    if (flush || stall_eff) begin
      ex_ex_d = '0;
      m_ex_d  = '0;
      wb_ex_d = '0;
      rt_ex_d = '0;
    end
    if (flush) begin
      m_mem_d  = '0;
      wb_mem_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_ex_q  <= '0;
      m_ex_q   <= '0;
      wb_ex_q  <= '0;
      rt_ex_q  <= '0;
      m_mem_q  <= '0;
      wb_mem_q <= '0;
      wb_wb_q  <= '0;
    end else begin
      ex_ex_q  <= ex_ex_d;
      m_ex_q   <= m_ex_d;
      wb_ex_q  <= wb_ex_d;
      rt_ex_q  <= rt_ex_d;
      m_mem_q  <= m_mem_d;
      wb_mem_q <= wb_mem_d;
      wb_wb_q  <= wb_wb_d;
    end
  end

  assign EX_ex  = ex_ex_q;
  assign M_ex   = m_ex_q;
  assign WB_ex  = wb_ex_q;
  assign M_mem  = m_mem_q;
  assign WB_mem = wb_mem_q;
  assign WB_wb  = wb_wb_q;

`ifdef CTRL_PIPE_EVENT_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_eff && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe (CNT_W=4); counter expectations follow CTRL_PIPE_EVENT_CNT_EN.
module tb_ctrl_pipe;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [8:0] EX_id;
  logic [4:0] M_id;
  logic [3:0] WB_id;
  logic       ID_id;
  logic [4:0] Rs_id;
  logic [4:0] Rt_id;
  logic       BranchTaken_mem;
  logic [8:0] EX_ex;
  logic [4:0] M_ex;
  logic [3:0] WB_ex;
  logic [4:0] M_mem;
  logic [3:0] WB_mem;
  logic [3:0] WB_wb;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IFFlush;
  logic [3:0] StallCnt;
  logic [3:0] FlushCnt;

  int checks = 0;
  int errors = 0;
  int n_sc   = 0;
  int n_fc   = 0;

  ctrl_pipe #(.CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .EX_id(EX_id), .M_id(M_id), .WB_id(WB_id),
    .ID_id(ID_id), .Rs_id(Rs_id), .Rt_id(Rt_id), .BranchTaken_mem(BranchTaken_mem),
    .EX_ex(EX_ex), .M_ex(M_ex), .WB_ex(WB_ex), .M_mem(M_mem), .WB_mem(WB_mem),
    .WB_wb(WB_wb), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFFlush(IFFlush),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] cnt_exp(input int n);
`ifdef CTRL_PIPE_EVENT_CNT_EN
    return (n > 15) ? 4'hF : 4'(n);
`else
    return 4'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] ex, input logic [4:0] m, input logic [3:0] wb,
                       input logic jmp, input logic [4:0] rs, input logic [4:0] rt,
                       input logic bt);
    EX_id = ex; M_id = m; WB_id = wb; ID_id = jmp;
    Rs_id = rs; Rt_id = rt; BranchTaken_mem = bt;
    #1;
  endtask

  task automatic nop();
    drive(9'h000, 5'h00, 4'h0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(9'h1FF, 5'h1F, 4'hF, 1'b0, 5'd3, 5'd3, 1'b0);
    tick(); tick();
    checks++;
    if ({EX_ex, M_ex, WB_ex, M_mem, WB_mem, WB_wb} !== 31'h0) begin
      errors++; $display("FAIL reset_bundles got %h exp 0", {EX_ex, M_ex, WB_ex, M_mem, WB_mem, WB_wb});
    end
    checks++;
    if ({PCWrite, IFIDWrite, IFFlush} !== 3'b110) begin
      errors++; $display("FAIL reset_fetch_ctl got %b exp 110", {PCWrite, IFIDWrite, IFFlush});
    end
    checks++;
    if ({StallCnt, FlushCnt} !== 8'h00) begin
      errors++; $display("FAIL reset_counters got %h exp 00", {StallCnt, FlushCnt});
    end
    Reset = 1'b0;
    n_sc = 0; n_fc = 0;
    nop();
    tick();
  endtask

  task automatic test_latency();
    drive(9'h02C, 5'h00, 4'h3, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    checks++;
    if ({EX_ex, M_ex, WB_ex} !== {9'h02C, 5'h00, 4'h3}) begin
      errors++; $display("FAIL latency_ex got %h exp %h", {EX_ex, M_ex, WB_ex}, {9'h02C, 5'h00, 4'h3});
    end
    nop();
    tick();
    checks++;
    if ({EX_ex, M_mem, WB_mem} !== {9'h000, 5'h00, 4'h3}) begin
      errors++; $display("FAIL latency_mem got %h exp %h", {EX_ex, M_mem, WB_mem}, {9'h000, 5'h00, 4'h3});
    end
    tick();
    checks++;
    if ({WB_mem, WB_wb} !== 8'h03) begin
      errors++; $display("FAIL latency_wb got %h exp 03", {WB_mem, WB_wb});
    end
  endtask

  task automatic test_back_to_back();
    drive(9'h001, 5'h10, 4'h1, 1'b0, 5'd1, 5'd2, 1'b0); tick();
    drive(9'h002, 5'h04, 4'h2, 1'b0, 5'd3, 5'd4, 1'b0); tick();
    drive(9'h004, 5'h01, 4'h4, 1'b0, 5'd5, 5'd6, 1'b0); tick();
    checks++;
    if ({EX_ex, M_ex, WB_ex, M_mem, WB_mem, WB_wb} !== {9'h004, 5'h01, 4'h4, 5'h04, 4'h2, 4'h1}) begin
      errors++; $display("FAIL back_to_back got %h exp %h", {EX_ex, M_ex, WB_ex, M_mem, WB_mem, WB_wb},
                         {9'h004, 5'h01, 4'h4, 5'h04, 4'h2, 4'h1});
    end
    checks++;
    if ({PCWrite, IFIDWrite, IFFlush} !== 3'b110) begin
      errors++; $display("FAIL back_to_back_fetch got %b exp 110", {PCWrite, IFIDWrite, IFFlush});
    end
    nop(); tick(); tick(); tick();
  endtask

  task automatic test_load_use();
    drive(9'h02C, 5'h08, 4'h3, 1'b0, 5'd1, 5'd5, 1'b0); tick();
    drive(9'h044, 5'h00, 4'h1, 1'b0, 5'd5, 5'd2, 1'b0);
    checks++;
    if ({PCWrite, IFIDWrite, IFFlush} !== 3'b000) begin
      errors++; $display("FAIL load_use_stall got %b exp 000", {PCWrite, IFIDWrite, IFFlush});
    end
    tick(); n_sc++;
    checks++;
    if ({EX_ex, M_ex, WB_ex, M_mem, WB_mem} !== {9'h000, 5'h00, 4'h0, 5'h08, 4'h3}) begin
      errors++; $display("FAIL load_use_bubble got %h exp %h", {EX_ex, M_ex, WB_ex, M_mem, WB_mem},
                         {9'h000, 5'h00, 4'h0, 5'h08, 4'h3});
    end
    checks++;
    if (StallCnt !== cnt_exp(n_sc)) begin
      errors++; $display("FAIL load_use_stallcnt got %h exp %h", StallCnt, cnt_exp(n_sc));
    end
    checks++;
    if ({PCWrite, IFIDWrite} !== 2'b11) begin
      errors++; $display("FAIL load_use_release got %b exp 11", {PCWrite, IFIDWrite});
    end
    tick();
    checks++;
    if ({EX_ex, WB_ex, WB_wb} !== {9'h044, 4'h1, 4'h3}) begin
      errors++; $display("FAIL load_use_redecode got %h exp %h", {EX_ex, WB_ex, WB_wb}, {9'h044, 4'h1, 4'h3});
    end
    // Match through the Rt field of the dependent instruction.
    drive(9'h02C, 5'h08, 4'h3, 1'b0, 5'd0, 5'd6, 1'b0); tick();
    drive(9'h044, 5'h00, 4'h1, 1'b0, 5'd1, 5'd6, 1'b0);
    checks++;
    if ({PCWrite, IFIDWrite} !== 2'b00) begin
      errors++; $display("FAIL load_use_rt_match got %b exp 00", {PCWrite, IFIDWrite});
    end
    tick(); n_sc++;
    nop(); tick(); tick(); tick();
  endtask

  task automatic test_rt_zero();
    drive(9'h02C, 5'h08, 4'h3, 1'b0, 5'd1, 5'd0, 1'b0); tick();
    drive(9'h033, 5'h00, 4'h2, 1'b0, 5'd0, 5'd0, 1'b0);
    checks++;
    if ({PCWrite, IFIDWrite} !== 2'b11) begin
      errors++; $display("FAIL rt_zero_nostall got %b exp 11", {PCWrite, IFIDWrite});
    end
    tick();
    checks++;
    if (EX_ex !== 9'h033) begin
      errors++; $display("FAIL rt_zero_advance got %h exp 033", EX_ex);
    end
    nop(); tick(); tick(); tick();
  endtask

  task automatic test_flush();
    drive(9'h000, 5'h00, 4'h5, 1'b0, 5'd1, 5'd2, 1'b0); tick();
    drive(9'h02C, 5'h08, 4'h3, 1'b0, 5'd1, 5'd7, 1'b0); tick();
    drive(9'h044, 5'h00, 4'h1, 1'b0, 5'd7, 5'd2, 1'b1);
    checks++;
    if ({IFFlush, PCWrite, IFIDWrite} !== 3'b111) begin
      errors++; $display("FAIL flush_fetch_ctl got %b exp 111", {IFFlush, PCWrite, IFIDWrite});
    end
    tick(); n_fc++;
    checks++;
    if ({EX_ex, M_ex, WB_ex, M_mem, WB_mem, WB_wb} !== {9'h000, 5'h00, 4'h0, 5'h00, 4'h0, 4'h5}) begin
      errors++; $display("FAIL flush_bubbles got %h exp %h", {EX_ex, M_ex, WB_ex, M_mem, WB_mem, WB_wb},
                         {9'h000, 5'h00, 4'h0, 5'h00, 4'h0, 4'h5});
    end
    checks++;
    if ({StallCnt, FlushCnt} !== {cnt_exp(n_sc), cnt_exp(n_fc)}) begin
      errors++; $display("FAIL flush_counters got %h exp %h", {StallCnt, FlushCnt}, {cnt_exp(n_sc), cnt_exp(n_fc)});
    end
    nop(); tick(); tick(); tick();
  endtask

  task automatic test_jump();
    drive(9'h000, 5'h00, 4'h0, 1'b1, 5'd1, 5'd2, 1'b0);
    checks++;
    if ({IFFlush, PCWrite} !== 2'b11) begin
      errors++; $display("FAIL jump_flush got %b exp 11", {IFFlush, PCWrite});
    end
    tick();
    nop();
    checks++;
    if (IFFlush !== 1'b0) begin
      errors++; $display("FAIL jump_one_cycle got %b exp 0", IFFlush);
    end
    drive(9'h02C, 5'h08, 4'h3, 1'b0, 5'd0, 5'd9, 1'b0); tick();
    drive(9'h000, 5'h00, 4'h0, 1'b1, 5'd9, 5'd0, 1'b0);
    checks++;
    if ({IFFlush, PCWrite} !== 2'b00) begin
      errors++; $display("FAIL jump_stalled got %b exp 00", {IFFlush, PCWrite});
    end
    tick(); n_sc++;
    checks++;
    if ({IFFlush, PCWrite} !== 2'b11) begin
      errors++; $display("FAIL jump_redecode got %b exp 11", {IFFlush, PCWrite});
    end
    tick();
    nop(); tick(); tick(); tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      drive(9'h02C, 5'h08, 4'h3, 1'b0, 5'd0, 5'd5, 1'b0); tick();
      drive(9'h000, 5'h00, 4'h0, 1'b0, 5'd5, 5'd0, 1'b0); tick();
      n_sc++;
    end
    checks++;
    if (StallCnt !== cnt_exp(n_sc)) begin
      errors++; $display("FAIL stall_saturate got %h exp %h", StallCnt, cnt_exp(n_sc));
    end
    drive(9'h000, 5'h00, 4'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_fc++;
    end
    checks++;
    if ({StallCnt, FlushCnt} !== {cnt_exp(n_sc), cnt_exp(n_fc)}) begin
      errors++; $display("FAIL flush_saturate got %h exp %h", {StallCnt, FlushCnt}, {cnt_exp(n_sc), cnt_exp(n_fc)});
    end
    drive(9'h02C, 5'h08, 4'h3, 1'b0, 5'd0, 5'd5, 1'b0); tick();
    drive(9'h02C, 5'h00, 4'h3, 1'b0, 5'd1, 5'd2, 1'b0); tick();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({EX_ex, M_ex, WB_ex, M_mem, WB_mem, WB_wb, StallCnt, FlushCnt} !== 39'h0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {EX_ex, M_ex, WB_ex, M_mem, WB_mem, WB_wb, StallCnt, FlushCnt});
    end
    #1 Reset = 1'b0;
    n_sc = 0; n_fc = 0;
    drive(9'h02C, 5'h00, 4'h3, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    checks++;
    if ({EX_ex, WB_ex, M_mem, WB_mem} !== {9'h02C, 4'h3, 5'h00, 4'h0}) begin
      errors++; $display("FAIL post_reset_load got %h exp %h", {EX_ex, WB_ex, M_mem, WB_mem}, {9'h02C, 4'h3, 5'h00, 4'h0});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_load_use();
    test_rt_zero();
    test_flush();
    test_jump();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-002 SHALL have port Clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have decode-stage inputs from the controller: EX_id [8:0] (shsb/ALUOp/ALUSrc/RegDst), M_id [4:0] (Branch/MemRead/MemWrite/specBranch/BNE), WB_id [3:0] (lblh/MemtoReg/RegWrite), ID_id [0] (jump).
REQ-005 SHALL have inputs Rs_id [4:0] and Rt_id [4:0], the decode-stage source register fields.
REQ-006 SHALL have input BranchTaken_mem [0], asserted when the branch in MEM resolves taken.
REQ-007 SHALL have outputs EX_ex [8:0], M_ex [4:0], WB_ex [3:0], the ID/EX control register contents.
REQ-008 SHALL have outputs M_mem [4:0] and WB_mem [3:0] (EX/MEM), and WB_wb [3:0] (MEM/WB).
REQ-009 SHALL have outputs PCWrite [0], IFIDWrite [0] and IFFlush [0] to the fetch stage.
REQ-010 SHALL have outputs StallCnt [CNT_W-1:0] and FlushCnt [CNT_W-1:0].

Function
REQ-011 A bubble SHALL be all control fields zero: EX=0, M=0, WB=0, jump=0.
REQ-012 Each edge: SHALL shift the ID/EX Rt field plus EX/M/WB bundles down the stages; MEM/WB<=WB_mem; EX/MEM<={M_ex,WB_ex}; ID/EX<=decode inputs, including Rt_id.
REQ-013 Load-use Stall SHALL be combinational: M_ex[3]=1 AND Rt_ex!=0 AND (Rt_ex==Rs_id OR Rt_ex==Rt_id).
REQ-014 When Stall=1 and BranchTaken_mem=0: PCWrite=0, IFIDWrite=0, ID/EX SHALL load a bubble next edge, and EX/MEM and MEM/WB SHALL advance normally.
REQ-015 When BranchTaken_mem=1: ID/EX and EX/MEM SHALL load bubbles next edge, IFFlush=1, PCWrite=1, IFIDWrite=1, and Stall SHALL be ignored.
REQ-016 When ID_id=1, Stall=0 and BranchTaken_mem=0: IFFlush=1 for that cycle and the jump bundle SHALL enter ID/EX normally.
REQ-017 When jump coincides with Stall: IFFlush=0; the jump is re-decoded next cycle.
REQ-018 Otherwise PCWrite=1, IFIDWrite=1 and IFFlush=0.
REQ-019 Latency SHALL be decode->EX_ex 1 edge, ->M_mem 2 edges, ->WB_wb 3 edges, with no loss or duplication absent a stall or flush.
REQ-020 Stall and flush SHALL NOT alter MEM/WB; the instruction in MEM still writes back.
REQ-021 Counter update rules:
- StallCnt SHALL increment on each edge where Stall=1 and BranchTaken_mem=0.
- FlushCnt SHALL increment on each edge where BranchTaken_mem=1.
- Both SHALL saturate at all-ones and never wrap.

Reset
REQ-022 Reset=1 SHALL immediately clear all pipeline registers, Rt_ex and both counters, independent of Clk.
REQ-023 During and after reset, outputs SHALL be: all bundles 0, PCWrite=1, IFIDWrite=1, IFFlush=0 (given BranchTaken_mem=0, ID_id=0).
REQ-024 Reset asserted mid-stall or mid-flush SHALL discard all in-flight controls; the first edge after deassertion loads the decode inputs.

Configuration
REQ-025 Macro CTRL_PIPE_EVENT_CNT_EN defined: StallCnt and FlushCnt SHALL be implemented per REQ-021.
REQ-026 Macro CTRL_PIPE_EVENT_CNT_EN undefined: the ports SHALL remain present and be constant 0, with no counter registers.

Verification
REQ-027 ADDI bundle (EX=9'h02C, WB=4'h3) applied at edge 0 -> EX_ex=9'h02C after edge 1; WB_mem=4'h3 after edge 2; WB_wb=4'h3 after edge 3.
REQ-028 LW in ID/EX with Rt_ex=5, then decode Rs_id=5 -> Stall: PCWrite=0, IFIDWrite=0; next edge EX_ex=M_ex=WB_ex=0; StallCnt 0->1.
REQ-029 Load-use with Rt_ex=0 and Rs_id=0 -> no stall, PCWrite=1.
REQ-030 BranchTaken_mem=1 with Stall=1 in the same cycle -> IFFlush=1, PCWrite=1; next edge ID/EX=EX/MEM=0, WB_wb=prior WB_mem; FlushCnt+1, StallCnt unchanged.
REQ-031 Jump (ID_id=1) decoded: IFFlush=1 for one cycle; with Stall also asserted, IFFlush=0 that cycle and 1 on the re-decode.
REQ-032 CNT_W=4, Stall held for 20 cycles -> StallCnt=4'hF; pulse Reset asynchronously mid-hold -> counters and all bundles 0 before the next edge.
